// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/ack channel plus the decoded-side
// valid/ready output channel.
interface instr_fetch_queue_if #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_ack, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_ack, imem_rdata, out_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC generation, req/ack memory fetch, a small
// {pc, instr} queue towards decode, and redirect flushing of queue and in-flight fetch.
module instr_fetch_queue #(
    parameter int PC_W     = 6,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 redirect,
    input  logic [PC_W-1:0]      redirect_pc,
    instr_fetch_queue_if.master  fq
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t          state_reg, state_next;
    logic            req_reg, req_next;
    logic [PC_W-1:0] addr_reg, addr_next;
    logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PC_W-1:0] pending_pc_reg, pending_pc_next;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push, pop, flush;
    logic             credit_idle, credit_push;

    logic [DEPTH-1:0][PC_W-1:0]    ent_pc;
    logic [DEPTH-1:0][INSTR_W-1:0] ent_instr;

    assign flush = redirect;
    assign pop   = (count_reg != '0) && fq.out_ready;

    // Credit is judged on the occupancy this cycle will leave behind, so the
    // ack of any request launched now is guaranteed a free slot.
    assign credit_idle = (int'(count_reg) - int'(pop)) < DEPTH;
    assign credit_push = (int'(count_reg) + 1 - int'(pop)) < DEPTH;

    always_comb begin
        state_next      = state_reg;
        req_next        = req_reg;
        addr_next       = addr_reg;
        fetch_pc_next   = fetch_pc_reg;
        pending_pc_next = pending_pc_reg;
        push            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end else if (enable && credit_idle) begin
                    req_next   = 1'b1;
                    addr_next  = fetch_pc_reg;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (fq.imem_ack) begin
                    if (redirect) begin
                        fetch_pc_next = redirect_pc;
                        req_next      = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        push          = 1'b1;
                        fetch_pc_next = addr_reg + 1'b1;
                        if (enable && credit_push) begin
                            addr_next = addr_reg + 1'b1;
                        end else begin
                            req_next   = 1'b0;
                            state_next = IDLE;
                        end
                    end
                end else if (redirect) begin
                    pending_pc_next = redirect_pc;
                    state_next      = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pending_pc_next = redirect_pc;
                end
                if (fq.imem_ack) begin
                    fetch_pc_next = redirect ? redirect_pc : pending_pc_reg;
                    req_next      = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            req_reg        <= 1'b0;
            addr_reg       <= PC_W'(RESET_PC);
            fetch_pc_reg   <= PC_W'(RESET_PC);
            pending_pc_reg <= '0;
        end else begin
            state_reg      <= state_next;
            req_reg        <= req_next;
            addr_reg       <= addr_next;
            fetch_pc_reg   <= fetch_pc_next;
            pending_pc_reg <= pending_pc_next;
        end
    end

    // Redirect wins over push and pop: the whole queue is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PC_W-1:0]    pc_reg;
        logic [INSTR_W-1:0] instr_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pc_reg    <= '0;
                instr_reg <= '0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                pc_reg    <= addr_reg;
                instr_reg <= fq.imem_rdata;
            end
        end

        assign ent_pc[gi]    = pc_reg;
        assign ent_instr[gi] = instr_reg;
    end

    assign fq.imem_req  = req_reg;
    assign fq.imem_addr = addr_reg;
    assign fq.out_valid = (count_reg != '0);
    assign fq.out_pc    = ent_pc[rd_ptr_reg];
    assign fq.out_instr = ent_instr[rd_ptr_reg];
endmodule
